// File: rtl/solitaire_pkg.sv
// Shared peg-solitaire definitions: board geometry, move directions and the
// square-existence test used by both the move controller and the board.
package solitaire_pkg;

  localparam int         BOARD_WIDTH = 7;
  localparam logic [2:0] PARK_COORD  = 3'd7;
  localparam logic [2:0] MAX_COORD   = 3'(BOARD_WIDTH - 1);

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } direction_e;

  typedef enum logic [1:0] {
    ST_NAV   = 2'd0,
    ST_ARMED = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } move_state_e;

  // Cross-shaped board: a square exists where the row or the column is central.
  function automatic logic space_exists(input logic [2:0] x, input logic [2:0] y);
    logic in_range_s;
    logic x_mid_s;
    logic y_mid_s;
    in_range_s   = (x <= MAX_COORD) && (y <= MAX_COORD);
    x_mid_s      = (x >= 3'd2) && (x <= 3'd4);
    y_mid_s      = (y >= 3'd2) && (y <= 3'd4);
    space_exists = in_range_s && (x_mid_s || y_mid_s);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: two-flop synchroniser, stability counter and a single-cycle
// pulse when the accepted level rises.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the raw asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has stayed different for the full count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        cnt_r   <= '0;
        level_r <= sync2_r;
        press_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/solitaire_move_ctrl.sv
// Peg-solitaire front end: debounces five buttons, steers a cursor over legal
// squares and issues one-cycle move requests to the board.
module solitaire_move_ctrl
  import solitaire_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       game_over,
  output logic [2:0] piece_x,
  output logic [2:0] piece_y,
  output logic [1:0] direction,
  output logic       move_strobe,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       armed
);

  logic [4:0]  btn_raw_s;
  logic [4:0]  press_s;
  logic        arrow_s;
  logic        select_s;
  direction_e  arrow_dir_s;
  logic [2:0]  tgt_x_s;
  logic [2:0]  tgt_y_s;

  move_state_e state_r, state_n;
  logic [2:0]  cursor_x_r, cursor_x_n;
  logic [2:0]  cursor_y_r, cursor_y_n;
  logic [2:0]  piece_x_r, piece_x_n;
  logic [2:0]  piece_y_r, piece_y_n;
  direction_e  dir_r, dir_n;
  logic        strobe_r, strobe_n;
  logic        armed_r, armed_n;

  assign btn_raw_s = {btn_select, btn_down, btn_up, btn_right, btn_left};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_raw_s[g]),
      .press (press_s[g])
    );
  end

  // Fixed-priority arbitration: left > right > up > down > select.
  always_comb begin
    arrow_s     = 1'b0;
    select_s    = 1'b0;
    arrow_dir_s = LEFT;
    if (press_s[0]) begin
      arrow_s     = 1'b1;
      arrow_dir_s = LEFT;
    end else if (press_s[1]) begin
      arrow_s     = 1'b1;
      arrow_dir_s = RIGHT;
    end else if (press_s[2]) begin
      arrow_s     = 1'b1;
      arrow_dir_s = UP;
    end else if (press_s[3]) begin
      arrow_s     = 1'b1;
      arrow_dir_s = DOWN;
    end else if (press_s[4]) begin
      select_s    = 1'b1;
    end else begin
      select_s    = 1'b0;
    end
  end

  // Neighbouring square; 3-bit wrap at the edges lands on 7, which is never a square.
  always_comb begin
    tgt_x_s = cursor_x_r;
    tgt_y_s = cursor_y_r;
    case (arrow_dir_s)
      LEFT:    tgt_x_s = cursor_x_r - 3'd1;
      RIGHT:   tgt_x_s = cursor_x_r + 3'd1;
      UP:      tgt_y_s = cursor_y_r - 3'd1;
      DOWN:    tgt_y_s = cursor_y_r + 3'd1;
      default: tgt_x_s = cursor_x_r;
    endcase
  end

  // Next-state and registered-output values; coordinates park unless a move issues.
  always_comb begin
    state_n    = state_r;
    cursor_x_n = cursor_x_r;
    cursor_y_n = cursor_y_r;
    piece_x_n  = PARK_COORD;
    piece_y_n  = PARK_COORD;
    dir_n      = dir_r;
    strobe_n   = 1'b0;
    armed_n    = 1'b0;
    case (state_r)
      ST_NAV: begin
        if (game_over) begin
          state_n = ST_DONE;
        end else if (arrow_s) begin
          if (space_exists(tgt_x_s, tgt_y_s)) begin
            cursor_x_n = tgt_x_s;
            cursor_y_n = tgt_y_s;
          end else begin
            cursor_x_n = cursor_x_r;
          end
        end else if (select_s) begin
          state_n = ST_ARMED;
          armed_n = 1'b1;
        end else begin
          state_n = ST_NAV;
        end
      end
      ST_ARMED: begin
        if (game_over) begin
          state_n = ST_DONE;
        end else if (arrow_s) begin
          state_n   = ST_ISSUE;
          dir_n     = arrow_dir_s;
          piece_x_n = cursor_x_r;
          piece_y_n = cursor_y_r;
          strobe_n  = 1'b1;
        end else if (select_s) begin
          state_n = ST_NAV;
        end else begin
          armed_n = 1'b1;
        end
      end
      ST_ISSUE: state_n = ST_NAV;
      ST_DONE:  state_n = ST_DONE;
      default:  state_n = ST_NAV;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_NAV;
      cursor_x_r <= 3'd3;
      cursor_y_r <= 3'd3;
      piece_x_r  <= PARK_COORD;
      piece_y_r  <= PARK_COORD;
      dir_r      <= LEFT;
      strobe_r   <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      cursor_x_r <= cursor_x_n;
      cursor_y_r <= cursor_y_n;
      piece_x_r  <= piece_x_n;
      piece_y_r  <= piece_y_n;
      dir_r      <= dir_n;
      strobe_r   <= strobe_n;
      armed_r    <= armed_n;
    end
  end

  assign piece_x     = piece_x_r;
  assign piece_y     = piece_y_r;
  assign direction   = dir_r;
  assign move_strobe = strobe_r;
  assign cursor_x    = cursor_x_r;
  assign cursor_y    = cursor_y_r;
  assign armed       = armed_r;

endmodule

// File: tb/tb_solitaire_move_ctrl.sv
// Self-checking bench for solitaire_move_ctrl with a short debounce count.
module tb_solitaire_move_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btns;
  logic       game_over;
  logic [2:0] piece_x, piece_y, cursor_x, cursor_y;
  logic [1:0] direction;
  logic       move_strobe, armed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] btn;
    int         hold;
    logic [2:0] cx;
    logic [2:0] cy;
    logic       arm;
    logic [1:0] dir;
    logic       strobe;
    logic [2:0] px;
    logic [2:0] py;
  } vec_t;

  typedef struct {
    logic [2:0] cx;
    logic [2:0] cy;
    logic       arm;
    logic [1:0] dir;
  } st_t;

  typedef struct {
    logic [2:0] px;
    logic [2:0] py;
    logic [1:0] dir;
  } mv_t;

  vec_t vecs[$];
  st_t  st_q[$];
  mv_t  mv_q[$];

  solitaire_move_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_left    (btns[0]),
    .btn_right   (btns[1]),
    .btn_up      (btns[2]),
    .btn_down    (btns[3]),
    .btn_select  (btns[4]),
    .game_over   (game_over),
    .piece_x     (piece_x),
    .piece_y     (piece_y),
    .direction   (direction),
    .move_strobe (move_strobe),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe scoreboard: every strobe must match a pushed expectation; otherwise parked.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (move_strobe === 1'b1) begin
        if (mv_q.size() == 0) begin
          chk("unexpected_strobe", 8'd1, 8'd0);
        end else begin
          mv_t m;
          m = mv_q.pop_front();
          chk("strobe_px", 8'(piece_x), 8'(m.px));
          chk("strobe_py", 8'(piece_y), 8'(m.py));
          chk("strobe_dir", 8'(direction), 8'(m.dir));
        end
      end else begin
        chk("parked_x", 8'(piece_x), 8'd7);
        chk("parked_y", 8'(piece_y), 8'd7);
      end
    end
  end

  task automatic press(input logic [4:0] b, input int hold);
    @(posedge clk);
    #1 btns = b;
    repeat (hold) @(posedge clk);
    #1 btns = 5'd0;
    repeat (14) @(posedge clk);
  endtask

  task automatic check_state(input string name);
    st_t e;
    e = st_q.pop_front();
    @(negedge clk);
    chk({name, "_cx"}, 8'(cursor_x), 8'(e.cx));
    chk({name, "_cy"}, 8'(cursor_y), 8'(e.cy));
    chk({name, "_armed"}, 8'(armed), 8'(e.arm));
    chk({name, "_dir"}, 8'(direction), 8'(e.dir));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    // btn order: {select, down, up, right, left}
    vecs.push_back('{5'b00100, 8,  3'd3, 3'd2, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b00100, 8,  3'd3, 3'd1, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b00100, 8,  3'd3, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b00100, 8,  3'd3, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b00001, 8,  3'd2, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b00001, 8,  3'd2, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b00010, 3,  3'd2, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b00010, 10, 3'd3, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b01000, 8,  3'd3, 3'd1, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b10000, 8,  3'd3, 3'd1, 1'b1, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b01000, 8,  3'd3, 3'd1, 1'b0, 2'd3, 1'b1, 3'd3, 3'd1});
    vecs.push_back('{5'b10000, 8,  3'd3, 3'd1, 1'b1, 2'd3, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b10000, 8,  3'd3, 3'd1, 1'b0, 2'd3, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b10001, 8,  3'd2, 3'd1, 1'b0, 2'd3, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b10000, 8,  3'd2, 3'd1, 1'b1, 2'd3, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b00001, 8,  3'd2, 3'd1, 1'b0, 2'd0, 1'b1, 3'd2, 3'd1});
    vecs.push_back('{5'b00010, 8,  3'd3, 3'd1, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0});
    vecs.push_back('{5'b10000, 8,  3'd3, 3'd1, 1'b1, 2'd0, 1'b0, 3'd0, 3'd0});

    rst_n     = 1'b0;
    btns      = 5'd0;
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cx", 8'(cursor_x), 8'd3);
    chk("rst_cy", 8'(cursor_y), 8'd3);
    chk("rst_px", 8'(piece_x), 8'd7);
    chk("rst_py", 8'(piece_y), 8'd7);
    chk("rst_strobe", 8'(move_strobe), 8'd0);
    chk("rst_armed", 8'(armed), 8'd0);
    chk("rst_dir", 8'(direction), 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      st_q.push_back('{vecs[i].cx, vecs[i].cy, vecs[i].arm, vecs[i].dir});
      if (vecs[i].strobe) mv_q.push_back('{vecs[i].px, vecs[i].py, vecs[i].dir});
      press(vecs[i].btn, vecs[i].hold);
      check_state($sformatf("vec%0d", i));
    end

    // game_over while armed: disarm and ignore everything afterwards
    @(posedge clk);
    #1 game_over = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("go_armed", 8'(armed), 8'd0);
    press(5'b00100, 8);
    press(5'b10000, 8);
    press(5'b01000, 8);
    @(negedge clk);
    chk("go_cx", 8'(cursor_x), 8'd3);
    chk("go_cy", 8'(cursor_y), 8'd1);
    chk("go_armed_after", 8'(armed), 8'd0);

    // Reset clears DONE; then reset again in the middle of a strobe cycle
    #1 rst_n = 1'b0;
    game_over = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_cx", 8'(cursor_x), 8'd3);
    chk("rst2_cy", 8'(cursor_y), 8'd3);
    press(5'b10000, 8);
    @(negedge clk);
    chk("rst2_armed", 8'(armed), 8'd1);
    mv_q.push_back('{3'd3, 3'd3, 2'd3});
    @(posedge clk);
    #1 btns = 5'b01000;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (move_strobe === 1'b1) seen = 1'b1;
    end
    chk("issue_seen", 8'(seen), 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("issue_rst_strobe", 8'(move_strobe), 8'd0);
    chk("issue_rst_px", 8'(piece_x), 8'd7);
    chk("issue_rst_cx", 8'(cursor_x), 8'd3);
    chk("issue_rst_cy", 8'(cursor_y), 8'd3);
    btns = 5'd0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("post_cx", 8'(cursor_x), 8'd3);
    chk("post_cy", 8'(cursor_y), 8'd3);
    chk("post_armed", 8'(armed), 8'd0);
    chk("mv_q_empty", 8'(mv_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
